// File: rtl/soc_regfile_controller_pkg.sv
// Shared definitions for the SOC control module: host opcodes, FSM states and
// the default settle time after the core clock is gated.
package soc_regfile_controller_pkg;

   localparam int SETTLE_CYCLES_DEFAULT = 2;

   typedef enum logic [1:0] {
      OP_HALT  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_DUMP  = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      IDLE,
      STOP_WAIT,
      RD_ADDR,
      RD_CAP,
      WR,
      DUMP_ADDR,
      DUMP_CAP,
      RSP,
      RELEASE
   } state_e;

   // First state of each command once the core is frozen and settled.
   function automatic state_e op_state(input op_e op);
      state_e s;
      s = RSP;
      unique case (op)
         OP_HALT:  s = RSP;
         OP_READ:  s = RD_ADDR;
         OP_WRITE: s = WR;
         OP_DUMP:  s = DUMP_ADDR;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/soc_regfile_controller_cpu_stop_sync.sv
// Core stop flop (falling edge, so the gated core clock never glitches) plus
// the settle counter that reports when the frozen core may be accessed.
module soc_regfile_controller_cpu_stop_sync #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic stop_req,
   output logic cm_cpu_stop,
   output logic settled
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

   logic [CNT_W-1:0] settle_cnt;

   // NOTE: stop changes only while clk is low; the core computes clk & ~stop,
   // so a rising-edge flop here would chop a high phase into a runt pulse.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) cm_cpu_stop <= 1'b0;
      else      cm_cpu_stop <= stop_req;
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       settle_cnt <= '0;
      else if (!stop_req)             settle_cnt <= '0;
      else if (settle_cnt != CNT_MAX) settle_cnt <= settle_cnt + 1'b1;
   end

   assign settled = (settle_cnt == CNT_MAX);

endmodule

// File: rtl/soc_regfile_controller.sv
// Responder-side control module: freezes the core, accesses its register file
// through the cm_* port and streams results back over a valid/ready channel.
module soc_regfile_controller
   import soc_regfile_controller_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_REGS       = 32,
   parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic                      cmd_release,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [REG_ADDR_WIDTH-1:0] rsp_addr,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_last,
   output logic                      cpu_halted,
   output logic                      cm_cpu_stop,
   output logic                      cm_regfile_we,
   output logic [REG_ADDR_WIDTH-1:0] cm_read_write_regfile_addr,
   output logic [DATA_WIDTH-1:0]     cm_write_regfile_dat,
   input  logic [DATA_WIDTH-1:0]     cm_read_regfile_dat
);

   localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_REGS - 1);

   state_e                      state, state_next;
   op_e                         op_q;
   logic [REG_ADDR_WIDTH-1:0]   addr_q, idx_q, beat_addr;
   logic [DATA_WIDTH-1:0]       wdata_q, rsp_data_q;
   logic                        release_q, stop_req, wr_hold, settled;
   logic                        accept, dispatch;

   soc_regfile_controller_cpu_stop_sync #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_stop_sync (
      .clk        (clk),
      .rst        (rst),
      .stop_req   (stop_req),
      .cm_cpu_stop(cm_cpu_stop),
      .settled    (settled)
   );

   // Dump beats walk the index; single-register commands use the latched address.
   assign beat_addr = (op_q == OP_DUMP) ? idx_q : addr_q;

   assign cmd_ready                  = rst && (state == IDLE);
   assign rsp_valid                  = (state == RSP);
   assign rsp_last                   = rsp_valid && ((op_q != OP_DUMP) || (idx_q == LAST_IDX));
   assign rsp_addr                   = rsp_valid ? beat_addr : '0;
   assign rsp_data                   = rsp_valid ? rsp_data_q : '0;
   assign cm_regfile_we              = (state == WR) && !wr_hold;
   assign cm_read_write_regfile_addr = beat_addr;
   assign cm_write_regfile_dat       = wdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      dispatch   = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept = 1'b1;
               // Core still frozen from a previous command: no need to re-settle.
               if (stop_req && settled) begin
                  dispatch   = 1'b1;
                  state_next = op_state(op_e'(cmd_op));
               end else begin
                  state_next = STOP_WAIT;
               end
            end
         end
         STOP_WAIT: begin
            if (settled) begin
               dispatch   = 1'b1;
               state_next = op_state(op_q);
            end
         end
         RD_ADDR:   state_next = RD_CAP;
         RD_CAP:    state_next = RSP;
         WR:        if (wr_hold) state_next = RSP;
         DUMP_ADDR: state_next = DUMP_CAP;
         DUMP_CAP:  state_next = RSP;
         RSP: begin
            if (rsp_ready) begin
               if (!rsp_last)      state_next = DUMP_ADDR;
               else if (release_q) state_next = RELEASE;
               else                state_next = IDLE;
            end
         end
         RELEASE:   state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= OP_HALT;
         addr_q     <= '0;
         wdata_q    <= '0;
         release_q  <= 1'b0;
         stop_req   <= 1'b0;
         cpu_halted <= 1'b0;
         idx_q      <= '0;
         rsp_data_q <= '0;
         wr_hold    <= 1'b0;
      end else begin
         if (accept) begin
            op_q      <= op_e'(cmd_op);
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            release_q <= cmd_release;
            stop_req  <= 1'b1;
         end
         if (dispatch) begin
            cpu_halted <= 1'b1;
            idx_q      <= '0;
            rsp_data_q <= '0;
         end
         wr_hold <= (state == WR) && !wr_hold;
         unique case (state)
            RD_CAP, DUMP_CAP: rsp_data_q <= cm_read_regfile_dat;
            WR:               rsp_data_q <= wdata_q;
            RSP:              if (rsp_ready && !rsp_last) idx_q <= idx_q + 1'b1;
            RELEASE: begin
               stop_req   <= 1'b0;
               cpu_halted <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/soc_regfile_controller.md
Name: soc_regfile_controller

Overview:
- Responder-side SOC Control Module for the core's `cm_*` register-file access port.
- Accepts host commands (halt, read register, write register, dump all registers) over a valid/ready command channel.
- Freezes the core through `cm_cpu_stop`, performs the register-file accesses, and returns results on a valid/ready response stream.
- Sits between the host/debug transport (UART or fault-injection module) and `riscv_cpu`.

Parameters:
- DATA_WIDTH, 32, register and data width.
- REG_ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of registers covered by a dump.
- SETTLE_CYCLES, 2, `clk` cycles to wait after `cm_cpu_stop` asserts before the first access (minimum 1).

Ports:
- clk  in  1  system clock, ungated.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts the command this cycle.
- cmd_op  in  2  00 HALT, 01 READ, 10 WRITE, 11 DUMP.
- cmd_addr  in  REG_ADDR_WIDTH  register index for READ/WRITE.
- cmd_wdata  in  DATA_WIDTH  write data for WRITE.
- cmd_release  in  1  release the core after this command completes.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  sink accepts the beat.
- rsp_addr  out  REG_ADDR_WIDTH  register index of the beat.
- rsp_data  out  DATA_WIDTH  register value (HALT returns 0).
- rsp_last  out  1  final beat of the command.
- cpu_halted  out  1  core is stopped and settled.
- cm_cpu_stop  out  1  to core: gate the core clock.
- cm_regfile_we  out  1  to core: register-file write enable.
- cm_read_write_regfile_addr  out  REG_ADDR_WIDTH  to core: register-file address.
- cm_write_regfile_dat  out  DATA_WIDTH  to core: register-file write data.
- cm_read_regfile_dat  in  DATA_WIDTH  from core: rs1 read data.

Behaviour:
- Reset (rst=0, asynchronous) forces all outputs to 0 and the state to IDLE. Reset mid-operation abandons the command with no response, and `cm_cpu_stop` drops immediately.
- `cm_cpu_stop` flop is the only flop clocked on negedge `clk`; everything else uses posedge.
  - The core gates its clock as `clk & ~cm_cpu_stop`, so stop must only change while `clk` is low, otherwise the gated clock glitches.
  - An FSM request `stop_req` set at posedge N reaches `cm_cpu_stop` at the following negedge, so the core's last edge is posedge N.
- `cmd_ready` = 1 only in IDLE. A handshake (valid & ready) latches op, addr, wdata and release.
- FSM states: IDLE, STOP_WAIT, RD_ADDR, RD_CAP, WR, DUMP_ADDR, DUMP_CAP, RSP, RELEASE.
- IDLE → STOP_WAIT on accept.
  - If the core is already halted (`stop_req`=1 and settle done), skip STOP_WAIT and go straight to the op state.
- STOP_WAIT counts SETTLE_CYCLES posedges with `stop_req` high, then sets `cpu_halted`=1 and dispatches:
  - HALT → RSP
  - READ → RD_ADDR
  - WRITE → WR
  - DUMP → DUMP_ADDR with index=0
- RD_ADDR drives `cm_read_write_regfile_addr`=addr. RD_CAP captures `cm_read_regfile_dat` one cycle later (register-file read latency is treated as ≤1 cycle), then → RSP.
- WR drives addr/dat with `cm_regfile_we`=1 for exactly one cycle. It then holds addr/dat for one more cycle with we=0, then → RSP with rsp_data=wdata.
  - A write to x0 is issued unchanged; the register file discards it.
- DUMP: DUMP_ADDR (present index) → DUMP_CAP (capture) → RSP per beat, with index incrementing 0..NUM_REGS-1.
  - rsp_last=1 only on index NUM_REGS-1; there is no wrap.
  - After a non-last beat is accepted → DUMP_ADDR.
- RSP holds rsp_valid/addr/data/last stable until rsp_ready. Backpressure of any length must be tolerated with the core still halted.
  - When the last beat is accepted: release=1 → RELEASE; release=0 → IDLE with `stop_req` still high.
- RELEASE clears `stop_req` and `cpu_halted`, then → IDLE. The core resumes at the first posedge after the negedge that deasserts stop.
- `cm_regfile_we` is never high while `cm_cpu_stop` is low.

Decomposition:
- Shared package/header `soc_ctrl_defs.vh` holds the opcode encodings (OP_HALT, OP_READ, OP_WRITE, OP_DUMP), the FSM state encodings and the SETTLE_CYCLES default.
- One natural sub-module: `cpu_stop_sync`, containing the negedge stop flop plus the settle counter, and producing `cm_cpu_stop` and a `settled` flag.

Test Plan:
- Reset with rst=0 mid-DUMP (beat 5) → all outputs 0 within the same cycle; after release, cmd_ready=1 and the core runs.
- Preload x7=0x0000_00A5 via the core (`addi`). READ addr=7, release=1 → one beat with rsp_addr=7, rsp_data=0x000000A5, rsp_last=1. The core's PC is frozen during the command and advances afterwards.
- WRITE addr=3, data=0xDEADBEEF, release=0, then READ addr=3, release=1 → rsp_data=0xDEADBEEF. Checks: exactly one `cm_regfile_we` pulse; no core write-back occurred; the second command skips STOP_WAIT.
- WRITE addr=0, data=0x12345678, then READ 0 → rsp_data=0.
- DUMP with rsp_ready toggling 1/0 every cycle → 32 beats with addr 0..31, in order, data matching the model, rsp_last only at 31, and rsp_* stable while stalled.
- Gated-clock check: HALT release=1 issued at an arbitrary phase → no gated-clock pulse narrower than half a period, and the core resumes exactly 1 instruction later.
